// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing-button stimulus generator.
package bounce_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // One step of the right-shifting Galois LFSR; a non-zero state never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bounce_gen_if.sv
// Command handshake into the bounce generator: "drive the button to cmd_level".
interface bounce_gen_if;

    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_level,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_level,
        output cmd_ready
    );

endinterface

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced so the state is never all-zero.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb state_d = lfsr_next(state_q);

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED_NZ;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/bounce_gen.sv
// Bouncing-button generator: on command, chatter the button an odd number of times
// with pseudo-random segment lengths, then hold it for a settle window and pulse done.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int                BOUNCE_MAX = 8,
    parameter int                GLITCH_W   = 8,
    parameter int                SETTLE_CYC = 1024,
    parameter logic              INIT_LEVEL = 1'b0,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    bounce_gen_if.slave  cmd,
    output logic         button,
    output logic         busy,
    output logic         done,
    output logic [7:0]   edge_cnt
);

    localparam int             SEG_W       = (GLITCH_W > 0) ? GLITCH_W : 1;
    localparam int             SET_W       = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [8:0]     BM_MOD      = 9'(BOUNCE_MAX + 1);

    logic [LFSR_W-1:0] lfsr_s;
    logic              lfsr_unused;
    logic [SEG_W-1:0]  seg_load;
    logic [8:0]        k_val;
    logic [8:0]        toggles_load;

    state_e            state_q, state_d;
    logic              button_q, button_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [7:0]        edge_cnt_q, edge_cnt_d;
    logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [8:0]        toggles_q, toggles_d;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_s)
    );

    // Only the low byte and the segment field are consumed; the rest is deliberately dropped.
    assign lfsr_unused = ^lfsr_s;

    generate
        if (GLITCH_W > 0) begin : g_seg
            assign seg_load = lfsr_s[GLITCH_W-1:0];
        end else begin : g_seg_zero
            assign seg_load = '0;
        end
    endgenerate

    // K extra toggle pairs, always giving an odd total so the final level matches the command.
    assign k_val        = {1'b0, lfsr_s[7:0]} % BM_MOD;
    assign toggles_load = {k_val[7:0], 1'b1};

    always_comb begin
        // NOTE: every _d defaults to its _q so no branch can leave a latch behind.
        state_d    = state_q;
        button_d   = button_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        edge_cnt_d = edge_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        settle_d   = settle_q;
        toggles_d  = toggles_q;

        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    edge_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    if (cmd.cmd_level != button_q) begin
                        state_d   = BOUNCE;
                        toggles_d = toggles_load;
                        seg_cnt_d = '0;
                    end else begin
                        state_d   = SETTLE;
                        toggles_d = 9'd0;
                        settle_d  = SETTLE_LOAD;
                    end
                end
            end
            BOUNCE: begin
                // seg_cnt of zero marks the end of a segment (or the entry cycle).
                if (seg_cnt_q == '0) begin
                    button_d   = ~button_q;
                    edge_cnt_d = (edge_cnt_q == 8'hFF) ? edge_cnt_q : edge_cnt_q + 8'd1;
                    toggles_d  = toggles_q - 9'd1;
                    seg_cnt_d  = seg_load;
                    if (toggles_q == 9'd1) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end else begin
                    seg_cnt_d = seg_cnt_q - SEG_W'(1);
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            button_q   <= INIT_LEVEL;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            edge_cnt_q <= 8'd0;
            seg_cnt_q  <= '0;
            settle_q   <= '0;
            toggles_q  <= 9'd0;
        end else begin
            state_q    <= state_d;
            button_q   <= button_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            edge_cnt_q <= edge_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            settle_q   <= settle_d;
            toggles_q  <= toggles_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign button        = button_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign edge_cnt      = edge_cnt_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Three generator configurations driven against a timeline model computed from the
// LFSR sequence; a behavioural debouncer watches the third instance.
`timescale 1ns/1ps
module tb_bounce_gen;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] vld, lvl, rdy, btn, bsy, dn;
    logic [7:0] ecnt [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bounce_gen_if bus0 ();
    bounce_gen_if bus1 ();
    bounce_gen_if bus2 ();

    assign bus0.cmd_valid = vld[0];
    assign bus0.cmd_level = lvl[0];
    assign rdy[0]         = bus0.cmd_ready;
    assign bus1.cmd_valid = vld[1];
    assign bus1.cmd_level = lvl[1];
    assign rdy[1]         = bus1.cmd_ready;
    assign bus2.cmd_valid = vld[2];
    assign bus2.cmd_level = lvl[2];
    assign rdy[2]         = bus2.cmd_ready;

    bounce_gen #(.BOUNCE_MAX(0), .GLITCH_W(0), .SETTLE_CYC(4), .INIT_LEVEL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .cmd(bus0),
        .button(btn[0]), .busy(bsy[0]), .done(dn[0]), .edge_cnt(ecnt[0]));

    bounce_gen u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cmd(bus1),
        .button(btn[1]), .busy(bsy[1]), .done(dn[1]), .edge_cnt(ecnt[1]));

    bounce_gen #(.BOUNCE_MAX(255), .GLITCH_W(1), .SETTLE_CYC(16), .INIT_LEVEL(1'b1),
                 .LFSR_SEED(16'h0000)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .cmd(bus2),
        .button(btn[2]), .busy(bsy[2]), .done(dn[2]), .edge_cnt(ecnt[2]));

    function automatic int p_bm(input int i);
        case (i) 0: return 0; 1: return 8; default: return 255; endcase
    endfunction
    function automatic int p_gw(input int i);
        case (i) 0: return 0; 1: return 8; default: return 1; endcase
    endfunction
    function automatic int p_sc(input int i);
        case (i) 0: return 4; 1: return 1024; default: return 16; endcase
    endfunction
    function automatic bit p_init(input int i);
        return (i == 2);
    endfunction
    function automatic logic [15:0] p_seed(input int i);
        return (i == 2) ? 16'h0001 : 16'hACE1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference LFSR per instance: the value visible in each cycle.
    logic [15:0] lfsr_m [3];
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            lfsr_m[i] <= rst_n[i] ? lfsr_step(lfsr_m[i]) : p_seed(i);

    // Behavioural debouncer on instance 2: output follows input once stable DB_N+1 samples.
    localparam int DB_N = 4;
    logic db_in_q, db_out;
    int   db_cnt, db_flips;
    always @(posedge clk) begin
        if (!rst_n[2]) begin
            db_in_q  <= 1'b1;
            db_out   <= 1'b1;
            db_cnt   <= 0;
            db_flips <= 0;
        end else if (btn[2] != db_in_q) begin
            db_in_q <= btn[2];
            db_cnt  <= 0;
        end else if (db_cnt < DB_N) begin
            db_cnt <= db_cnt + 1;
        end else if (db_out != db_in_q) begin
            db_out   <= db_in_q;
            db_flips <= db_flips + 1;
        end
    end

    bit btn_m  [3];
    int ecnt_m [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {cmd_ready, busy, done, button, edge_cnt}
    function automatic logic [11:0] obs(input int i);
        return {rdy[i], bsy[i], dn[i], btn[i], ecnt[i]};
    endfunction

    function automatic logic [11:0] idle_exp(input int i);
        return {1'b1, 1'b0, 1'b0, btn_m[i], 8'(ecnt_m[i])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int i, input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            check($sformatf("u%0d_idle", i), obs(i), idle_exp(i));
            if (i == 2) check("u2_db_idle", db_out, btn_m[2]);
        end
    endtask

    // Issue one command and compare every cycle up to and including the done cycle.
    // keep leaves cmd_valid high afterwards; abort_k >= 0 pulls reset after that edge.
    task automatic run_cmd(input int i, input bit level, input bit keep, input int abort_k);
        int          waited, ntog, kb, gw, pos, t, seg, done_k, n, idx, f0;
        logic [15:0] v, cur;
        int          tog_k [$];
        logic [11:0] e;
        vld[i] = 1'b1;
        lvl[i] = level;
        waited = 0;
        while (rdy[i] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (rdy[i] !== 1'b1) begin
            check($sformatf("u%0d_ready_timeout", i), rdy[i], 1);
            vld[i] = 1'b0;
            return;
        end
        // Accept happens at the coming edge; v is the LFSR value it will see.
        v  = lfsr_m[i];
        gw = p_gw(i);
        f0 = db_flips;
        tog_k.delete();
        ntog = 0;
        if (level != btn_m[i]) begin
            kb   = int'(v[7:0]) % (p_bm(i) + 1);
            ntog = 2 * kb + 1;
            cur  = v;
            pos  = 0;
            t    = 1;
            for (int m = 0; m < ntog; m++) begin
                tog_k.push_back(t);
                while (pos < t) begin
                    cur = lfsr_step(cur);
                    pos++;
                end
                seg = (gw == 0) ? 0 : int'(cur & 16'((1 << gw) - 1));
                t   = t + seg + 1;
            end
        end
        done_k = ((ntog == 0) ? 0 : tog_k[ntog-1]) + p_sc(i);
        tick();
        if (!keep) vld[i] = 1'b0;
        idx = 0;
        n   = 0;
        for (int k = 0; k <= done_k; k++) begin
            if (k > 0) tick();
            while (idx < ntog && tog_k[idx] <= k) begin
                idx++;
                n++;
            end
            e = {(k == done_k), (k < done_k), (k == done_k), btn_m[i] ^ n[0],
                 8'((n > 255) ? 255 : n)};
            check($sformatf("u%0d_k%0d", i, k), obs(i), e);
            if (k == abort_k && k < done_k) begin
                rst_n[i] = 1'b0;
                #1;
                check($sformatf("u%0d_rst_async", i), obs(i), {3'b100, p_init(i), 8'd0});
                tick();
                check($sformatf("u%0d_rst_hold", i), obs(i), {3'b100, p_init(i), 8'd0});
                @(negedge clk);
                rst_n[i]  = 1'b1;
                vld[i]    = 1'b0;
                btn_m[i]  = p_init(i);
                ecnt_m[i] = 0;
                return;
            end
            if (k < done_k) lvl[i] = 1'($urandom_range(0, 1));
        end
        btn_m[i]  = level;
        ecnt_m[i] = (ntog > 255) ? 255 : ntog;
        if (i == 2) begin
            check("u2_db_level", db_out, level);
            check("u2_db_flips", db_flips - f0, (ntog > 0) ? 1 : 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 3'b000;
        vld   = 3'b000;
        lvl   = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            btn_m[i]  = p_init(i);
            ecnt_m[i] = 0;
            check($sformatf("u%0d_reset", i), obs(i), idle_exp(i));
        end
        @(negedge clk);
        rst_n = 3'b111;
        tick();

        // Single toggle, short settle; then a same-level command; then back to 0.
        run_cmd(0, 1'b1, 1'b0, -1);
        idle_cycles(0, 2);
        run_cmd(0, 1'b1, 1'b0, -1);
        run_cmd(0, 1'b0, 1'b0, -1);
        idle_cycles(0, 2);

        // Default configuration: 0->1, 1->0, same level, aborted bounce, clean restart.
        run_cmd(1, 1'b1, 1'b0, -1);
        idle_cycles(1, 3);
        run_cmd(1, 1'b0, 1'b0, -1);
        run_cmd(1, 1'b0, 1'b0, -1);
        idle_cycles(1, 2);
        run_cmd(1, 1'b1, 1'b0, 3);
        idle_cycles(1, 2);
        run_cmd(1, 1'b1, 1'b0, -1);

        // cmd_valid held high with alternating levels: each accept lands in the done cycle.
        for (int c = 0; c < 10; c++) run_cmd(2, ~btn_m[2], 1'b1, -1);
        vld[2] = 1'b0;
        idle_cycles(2, 3);

        // Random commands with random gaps, watched by the debouncer.
        for (int c = 0; c < 40; c++) begin
            run_cmd(2, 1'($urandom_range(0, 1)), 1'b0, -1);
            idle_cycles(2, $urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable bouncing-button stimulus generator: the transmit-side counterpart of the board's button debouncer. It accepts a clean "go to level X" command over a valid/ready handshake and drives a single-bit `button` line that chatters pseudo-randomly before settling at X. It is then held stable for a fixed settle window and completion is reported. It sits in the test harness in front of a debouncer instance, or on a spare FPGA pin for loopback, and gives repeatable, seedable bounce for verification.

## Interface
- `BOUNCE_MAX`, 8: max extra toggle pairs per command (0..255)
- `GLITCH_W`, 8: bounce segment length is 1..2^GLITCH_W cycles
- `SETTLE_CYC`, 1024: stable-hold cycles after the final toggle (≥1)
- `INIT_LEVEL`, 1'b0: `button` value in reset
- `LFSR_SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_level`  in  1  target settled level
- `cmd_ready`  out  1  high in IDLE only
- `button`  out  1  generated (bouncing) line, registered
- `busy`  out  1  high in BOUNCE or SETTLE
- `done`  out  1  one-cycle pulse when settle window ends
- `edge_cnt`  out  8  toggles produced by the last/current command

## Operation
- FSM states: IDLE, BOUNCE, SETTLE.
- IDLE: `cmd_ready`=1. Accept on `cmd_valid & cmd_ready`.
  - `cmd_level != button`: load toggles_left = 2·K+1, K = lfsr[7:0] mod (BOUNCE_MAX+1). Go to BOUNCE.
  - `cmd_level == button`: toggles_left = 0. Go directly to SETTLE; `edge_cnt` cleared.
- BOUNCE: on entry and after each segment, toggle `button`, increment `edge_cnt`, decrement toggles_left, and load seg_cnt = lfsr[GLITCH_W-1:0] (segment length seg_cnt+1 cycles).
  - When the toggle that brings toggles_left to 0 occurs, go to SETTLE.
  - Toggle count is odd, so the final level always equals `cmd_level`.
- SETTLE: `button` held; count SETTLE_CYC cycles. Then return to IDLE and pulse `done` in the first IDLE cycle.
- `edge_cnt`: cleared on accept, saturates at 255, holds until next accept.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts every cycle out of reset regardless of state. It is never all-zero.
- `cmd_valid` while not ready is ignored (no queueing). `cmd_level` is sampled only at accept.

## Timing
- Reset values: `button`=INIT_LEVEL, `cmd_ready`=1, `busy`=0, `done`=0, `edge_cnt`=0, state IDLE, LFSR=LFSR_SEED (or 1).
- Accept at edge T → first `button` toggle visible after edge T+1; `busy` high from T+1.
- Each bounce segment holds `button` for exactly seg_cnt+1 cycles before the next toggle.
- Final toggle at edge F → SETTLE covers F+1..F+SETTLE_CYC. `done`=1, `cmd_ready`=1, `busy`=0 in the cycle after that.
- Same-level command: SETTLE begins at T+1 and `done` arrives SETTLE_CYC+1 cycles after accept.
- Back-to-back: a new command may be accepted in the same cycle `done` is high.
- `rst_n` low mid-operation aborts immediately and asynchronously: `button`→INIT_LEVEL, all outputs to reset values, with no `done`.
- Deterministic: same seed, same command stream, same cycle timing → identical `button` waveform.

## Structure
- Package `bounce_pkg`: state enum (IDLE/BOUNCE/SETTLE), `LFSR_TAPS`=16'hB400, `LFSR_W`=16.
- Sub-module `lfsr16` (clk, rst_n, seed param, 16-bit state out). The top holds the FSM, seg_cnt, settle counter, toggles_left and edge_cnt.
- Counter widths: seg_cnt GLITCH_W bits; settle counter $clog2(SETTLE_CYC+1); toggles_left 9 bits.

## Test plan
- Reset with INIT_LEVEL=0, then cmd level 1, BOUNCE_MAX=0, GLITCH_W=0, SETTLE_CYC=4 → exactly one toggle at T+1, `edge_cnt`=1, `done` at T+6, `button`=1 throughout.
- Defaults, cmd 0→1 then 1→0 → odd `edge_cnt` ≤17 each time; every segment length 1..256; final level matches the command; `button` stable for 1024 cycles before `done`.
- Cmd level equal to current `button` → `edge_cnt`=0, no toggles, `done` exactly 1025 cycles after accept.
- `cmd_valid` held high continuously with alternating levels → accept only when `cmd_ready`; a new accept occurs in the `done` cycle; no command lost or duplicated.
- Assert `rst_n`=0 mid-BOUNCE → `button`=INIT_LEVEL, `cmd_ready`=1, `busy`=0 immediately; no `done`; the next command after release starts cleanly from the seed.
- Bounce output feeding the debouncer, 50 random commands → debouncer output equals the commanded level once settled, with no spurious transitions after `done`.
